// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
//
// Machine-mode trap sequencer. It watches the committing instruction for
// ecall / ebreak / mret and (optionally) a pending machine timer interrupt.
// It then drives:
//   - a one-cycle CSR update strobe (mcause/mepc on trap, return on mret),
//   - a PC redirect handshake towards the fetch unit,
//   - a commit stall for as long as a sequence is in flight.
//
// Parameters
//   XLEN   data / address width
//   CNT_W  width of the trap counter
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   inst_valid                   an instruction commits this cycle
//   inst_ecall/ebreak/mret       decode of the committing instruction
//   inst_addr, inst_nxt_pc       PC of that instruction / of the next one
//   mstatus_mie, mie_mtie        interrupt enable bits
//   clint_mtip                   timer interrupt pending level
//   mtvec, mepc                  current CSR values
//   bus_busy                     AXI data transaction outstanding
//   csr_trap_we, csr_ret_we      one-cycle CSR update strobes
//   trap_cause, trap_epc         mcause / mepc values, valid with csr_trap_we
//   redirect_valid/ready/pc      PC redirect handshake
//   stall                        freezes commit while a sequence is active
//   trap_cnt                     number of traps taken (wraps)
//
// Configuration macro
//   TRAP_CTRL_TIMER_IRQ_EN  when defined, the timer interrupt path (including
//                           waiting for the data bus to drain) is built.
//                           Otherwise the interrupt inputs and bus_busy are
//                           ignored and only synchronous events are handled.
// ---------------------------------------------------------------------------
module trap_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    input  logic             inst_ecall,
    input  logic             inst_ebreak,
    input  logic             inst_mret,
    input  logic [XLEN-1:0]  inst_addr,
    input  logic [XLEN-1:0]  inst_nxt_pc,
    input  logic             mstatus_mie,
    input  logic             mie_mtie,
    input  logic             clint_mtip,
    input  logic [XLEN-1:0]  mtvec,
    input  logic [XLEN-1:0]  mepc,
    input  logic             bus_busy,
    output logic             csr_trap_we,
    output logic             csr_ret_we,
    output logic [XLEN-1:0]  trap_cause,
    output logic [XLEN-1:0]  trap_epc,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             stall,
    output logic [CNT_W-1:0] trap_cnt
);

    localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(11);
    localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(3);
    // Interrupt bit in the MSB, exception code 7 (machine timer).
    localparam logic [XLEN-1:0] CAUSE_TIMER  = {1'b1, {(XLEN-4){1'b0}}, 3'd7};

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUS,
        TRAP,
        RET,
        REDIRECT
    } state_t;

    state_t state;
    logic   irq_pend;
    logic   bus_hold;

`ifdef TRAP_CTRL_TIMER_IRQ_EN
    assign irq_pend = clint_mtip & mstatus_mie & mie_mtie;
    assign bus_hold = bus_busy;
`else
    // Without the interrupt path nothing can ever wait for the bus, so these
    // inputs are deliberately left unconnected to any logic.
    logic unused_irq_inputs;
    assign unused_irq_inputs = &{1'b0, clint_mtip, mstatus_mie, mie_mtie, bus_busy};
    assign irq_pend = 1'b0;
    assign bus_hold = 1'b0;
`endif

    // Single sequencer: every output is a register updated together with the
    // state, so the strobes line up exactly with the TRAP / RET cycles and
    // stall mirrors "state != IDLE" without a combinational path.
    // Once a timer interrupt is accepted its cause/epc are latched, so the
    // pending level dropping while waiting for the bus does not cancel it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            trap_cnt       <= '0;
            csr_trap_we    <= 1'b0;
            csr_ret_we     <= 1'b0;
            redirect_valid <= 1'b0;
            stall          <= 1'b0;
            trap_cause     <= '0;
            trap_epc       <= '0;
            redirect_pc    <= '0;
        end else begin
            csr_trap_we <= 1'b0;
            csr_ret_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_valid) begin
                        if (inst_ecall) begin
                            trap_cause  <= CAUSE_ECALL;
                            trap_epc    <= inst_addr;
                            csr_trap_we <= 1'b1;
                            stall       <= 1'b1;
                            state       <= TRAP;
                        end else if (inst_ebreak) begin
                            trap_cause  <= CAUSE_EBREAK;
                            trap_epc    <= inst_addr;
                            csr_trap_we <= 1'b1;
                            stall       <= 1'b1;
                            state       <= TRAP;
                        end else if (inst_mret) begin
                            csr_ret_we  <= 1'b1;
                            stall       <= 1'b1;
                            state       <= RET;
                        end else if (irq_pend) begin
                            trap_cause  <= CAUSE_TIMER;
                            trap_epc    <= inst_nxt_pc;
                            stall       <= 1'b1;
                            if (bus_hold) begin
                                state       <= WAIT_BUS;
                            end else begin
                                csr_trap_we <= 1'b1;
                                state       <= TRAP;
                            end
                        end
                    end
                end
                WAIT_BUS: begin
                    if (!bus_hold) begin
                        csr_trap_we <= 1'b1;
                        state       <= TRAP;
                    end
                end
                TRAP: begin
                    redirect_pc    <= mtvec;
                    redirect_valid <= 1'b1;
                    trap_cnt       <= trap_cnt + CNT_W'(1);
                    state          <= REDIRECT;
                end
                RET: begin
                    redirect_pc    <= mepc;
                    redirect_valid <= 1'b1;
                    state          <= REDIRECT;
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        stall          <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    redirect_valid <= 1'b0;
                    stall          <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl
//
// Directed bench for trap_ctrl. Stimulus tasks push the expected CSR strobes
// and redirect handshakes (with their cycle of arrival) into a queue; a
// monitor on the falling clock edge pops and compares whenever the DUT shows
// csr_trap_we, csr_ret_we or a completed redirect handshake.
// The counter is built 4 bits wide so that wrap-around is reachable.
// ---------------------------------------------------------------------------
module tb_trap_ctrl;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;
    localparam logic [63:0] CAUSE_ECALL  = 64'd11;
    localparam logic [63:0] CAUSE_EBREAK = 64'd3;
    localparam logic [63:0] CAUSE_TIMER  = 64'h8000_0000_0000_0007;

    typedef struct {
        int          kind;
        logic [63:0] val;
        logic [63:0] pc;
        int          cnt;
        int          cyc;
        int          vcnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             inst_valid = 1'b0;
    logic             inst_ecall = 1'b0;
    logic             inst_ebreak = 1'b0;
    logic             inst_mret = 1'b0;
    logic [XLEN-1:0]  inst_addr = '0;
    logic [XLEN-1:0]  inst_nxt_pc = '0;
    logic             mstatus_mie = 1'b0;
    logic             mie_mtie = 1'b0;
    logic             clint_mtip = 1'b0;
    logic [XLEN-1:0]  mtvec = 64'h8000_0800;
    logic [XLEN-1:0]  mepc = 64'h8000_0104;
    logic             bus_busy = 1'b0;
    logic             csr_trap_we;
    logic             csr_ret_we;
    logic [XLEN-1:0]  trap_cause;
    logic [XLEN-1:0]  trap_epc;
    logic             redirect_valid;
    logic             redirect_ready = 1'b0;
    logic [XLEN-1:0]  redirect_pc;
    logic             stall;
    logic [CNT_W-1:0] trap_cnt;

    exp_t        sb[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int          exp_cnt = 0;
    int          ready_delay = 0;
    int          rcnt = 0;
    int          vcnt = 0;
    logic [63:0] held_pc = '0;

    trap_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_valid     (inst_valid),
        .inst_ecall     (inst_ecall),
        .inst_ebreak    (inst_ebreak),
        .inst_mret      (inst_mret),
        .inst_addr      (inst_addr),
        .inst_nxt_pc    (inst_nxt_pc),
        .mstatus_mie    (mstatus_mie),
        .mie_mtie       (mie_mtie),
        .clint_mtip     (clint_mtip),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .bus_busy       (bus_busy),
        .csr_trap_we    (csr_trap_we),
        .csr_ret_we     (csr_ret_we),
        .trap_cause     (trap_cause),
        .trap_epc       (trap_epc),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .trap_cnt       (trap_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic void push_exp(input int kind, input logic [63:0] val, input logic [63:0] pc,
                                     input int cnt, input int ecyc, input int evcnt);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.pc   = pc;
        e.cnt  = cnt;
        e.cyc  = ecyc;
        e.vcnt = evcnt;
        sb.push_back(e);
    endfunction

    // Fetch side: hold ready low for ready_delay cycles of redirect_valid.
    always @(posedge clk) begin
        #1;
        if (redirect_valid) begin
            if (rcnt >= ready_delay) redirect_ready = 1'b1;
            rcnt++;
        end else begin
            redirect_ready = 1'b0;
            rcnt = 0;
        end
    end

    // Monitor: pops one expectation per DUT strobe / completed handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            vcnt = 0;
        end else begin
            if (redirect_valid) begin
                if (vcnt > 0) check_output("redirect_pc stable", redirect_pc, held_pc);
                held_pc = redirect_pc;
                vcnt++;
            end
            if (csr_trap_we) begin
                if (sb.size() == 0) begin
                    check_output("unexpected csr_trap_we", csr_trap_we, 0);
                end else begin
                    e = sb.pop_front();
                    check_output("trap order", 64'(e.kind), 0);
                    check_output("trap cause", trap_cause, e.val);
                    check_output("trap epc", trap_epc, e.pc);
                    check_output("trap cycle", 64'(cyc), 64'(e.cyc));
                    check_output("strobes exclusive", csr_ret_we, 0);
                end
            end
            if (csr_ret_we) begin
                if (sb.size() == 0) begin
                    check_output("unexpected csr_ret_we", csr_ret_we, 0);
                end else begin
                    e = sb.pop_front();
                    check_output("ret order", 64'(e.kind), 1);
                    check_output("ret cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (redirect_valid && redirect_ready) begin
                if (sb.size() == 0) begin
                    check_output("unexpected redirect", redirect_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check_output("redirect order", 64'(e.kind), 2);
                    check_output("redirect pc", redirect_pc, e.pc);
                    check_output("trap_cnt", 64'(trap_cnt), 64'(e.cnt));
                    check_output("redirect cycle", 64'(cyc), 64'(e.cyc));
                    check_output("redirect valid cycles", 64'(vcnt), 64'(e.vcnt));
                end
                vcnt = 0;
            end
        end
    end

    // All stimulus tasks run in the "#1 after rising edge" slot.
    task automatic wait_idle();
        int n = 0;
        while (stall !== 1'b0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check_output("wait for idle timeout", stall, 0);
    endtask

    // Present one commit, then keep bus_busy high through busy_cycles edges.
    task automatic apply_stimulus(input logic ec, input logic eb, input logic mr,
                                  input logic [63:0] addr, input logic [63:0] nxt,
                                  input int busy_cycles, input logic drop_irq);
        inst_valid  = 1'b1;
        inst_ecall  = ec;
        inst_ebreak = eb;
        inst_mret   = mr;
        inst_addr   = addr;
        inst_nxt_pc = nxt;
        bus_busy    = (busy_cycles > 0);
        @(posedge clk);
        #1;
        inst_valid  = 1'b0;
        inst_ecall  = 1'b0;
        inst_ebreak = 1'b0;
        inst_mret   = 1'b0;
        if (drop_irq) clint_mtip = 1'b0;
        repeat (busy_cycles - 1) begin
            @(posedge clk);
            #1;
        end
        bus_busy = 1'b0;
    endtask

    task automatic do_sync_trap(input logic ec, input logic eb, input logic mr,
                                input logic [63:0] addr, input int delay);
        int n;
        wait_idle();
        ready_delay = delay;
        n = cyc;
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        push_exp(0, ec ? CAUSE_ECALL : CAUSE_EBREAK, addr, 0, n + 1, 0);
        push_exp(2, 64'd0, mtvec, exp_cnt, n + 2 + delay, delay + 1);
        apply_stimulus(ec, eb, mr, addr, addr + 64'd4, 0, 1'b0);
    endtask

    task automatic do_mret(input int delay);
        int n;
        wait_idle();
        ready_delay = delay;
        n = cyc;
        push_exp(1, 64'd0, 64'd0, 0, n + 1, 0);
        push_exp(2, 64'd0, mepc, exp_cnt, n + 2 + delay, delay + 1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 64'h8000_0180, 64'h8000_0184, 0, 1'b0);
    endtask

    // Plain commit with the timer interrupt pending; mtip drops right after.
    task automatic do_irq(input logic [63:0] nxt, input int busy);
        int n;
        wait_idle();
        ready_delay = 0;
        n = cyc;
`ifdef TRAP_CTRL_TIMER_IRQ_EN
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        push_exp(0, CAUSE_TIMER, nxt, 0, n + 1 + busy, 0);
        push_exp(2, 64'd0, mtvec, exp_cnt, n + 2 + busy, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, nxt - 64'd4, nxt, busy, 1'b1);
`else
        apply_stimulus(1'b0, 1'b0, 1'b0, nxt - 64'd4, nxt, busy, 1'b1);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        check_output("irq disabled stall", stall, 0);
        check_output("irq disabled trap_cnt", 64'(trap_cnt), 64'(exp_cnt));
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_output("reset redirect_valid", redirect_valid, 0);
        check_output("reset stall", stall, 0);
        check_output("reset trap_cnt", 64'(trap_cnt), 0);
        check_output("reset csr_trap_we", csr_trap_we, 0);
        check_output("reset csr_ret_we", csr_ret_we, 0);
        check_output("reset trap_cause", trap_cause, 0);
        check_output("reset redirect_pc", redirect_pc, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ecall right after reset release, fixed latency.
        do_sync_trap(1'b1, 1'b0, 1'b0, 64'h8000_0100, 0);
        // ebreak with one cycle of backpressure.
        do_sync_trap(1'b0, 1'b1, 1'b0, 64'h8000_0120, 1);
        // mret with ready held low for three cycles.
        do_mret(3);
        // Priority: ecall over ebreak over mret.
        do_sync_trap(1'b1, 1'b1, 1'b1, 64'h8000_0140, 0);
        do_sync_trap(1'b0, 1'b1, 1'b1, 64'h8000_0160, 0);

        // Timer interrupt delayed by 5 busy bus cycles.
        mstatus_mie = 1'b1;
        mie_mtie    = 1'b1;
        clint_mtip  = 1'b1;
        do_irq(64'h8000_0200, 5);

        // Synchronous event wins; interrupt taken at the next commit.
        clint_mtip = 1'b1;
        do_sync_trap(1'b1, 1'b0, 1'b0, 64'h8000_0300, 0);
        do_irq(64'h8000_0308, 0);

        // Pending interrupt with no commit is ignored.
        wait_idle();
        clint_mtip = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check_output("no commit no trap", stall, 0);
        clint_mtip = 1'b0;

        // Counter wrap.
        while (exp_cnt != (1 << CNT_W) - 1) do_sync_trap(1'b1, 1'b0, 1'b0, 64'h8000_0400, 0);
        do_sync_trap(1'b1, 1'b0, 1'b0, 64'h8000_0404, 0);
        wait_idle();
        check_output("trap_cnt wrapped", 64'(trap_cnt), 0);

        // Asynchronous reset in the middle of REDIRECT.
        wait_idle();
        ready_delay = 1000;
        n = cyc;
        push_exp(0, CAUSE_ECALL, 64'h8000_0500, 0, n + 1, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 64'h8000_0500, 64'h8000_0504, 0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_output("async reset redirect_valid", redirect_valid, 0);
        check_output("async reset stall", stall, 0);
        check_output("async reset trap_cnt", 64'(trap_cnt), 0);
        check_output("async reset redirect_pc", redirect_pc, 0);
        check_output("async reset trap_epc", trap_epc, 0);
        sb.delete();
        exp_cnt = 0;
        ready_delay = 0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("post reset redirect_valid", redirect_valid, 0);
        do_sync_trap(1'b1, 1'b0, 1'b0, 64'h8000_0600, 0);

        // Drain the scoreboard.
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("scoreboard drained", 64'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, data and address width.
REQ-002 SHALL have parameter CNT_W, default 32, width of the trap counter.
REQ-003 SHALL have clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 SHALL have rst  input  1  asynchronous reset, active-low.
REQ-005 SHALL have inst_valid  input  1  an instruction commits this cycle.
REQ-006 SHALL have inst_ecall / inst_ebreak / inst_mret  input  1 each  decode of the committing instruction.
REQ-007 SHALL have inst_addr / inst_nxt_pc  input  XLEN each  PC of the committing instruction / PC of the following instruction.
REQ-008 SHALL have mstatus_mie / mie_mtie / clint_mtip  input  1 each  interrupt-enable bits and timer-pending level.
REQ-009 SHALL have mtvec / mepc  input  XLEN each  current CSR values.
REQ-010 SHALL have bus_busy  input  1  AXI data transaction outstanding.
REQ-011 SHALL have csr_trap_we / csr_ret_we  output  1 each  one-cycle CSR update strobes.
REQ-012 SHALL have trap_cause / trap_epc  output  XLEN each  values for mcause / mepc, valid with csr_trap_we.
REQ-013 SHALL have redirect_valid / redirect_ready  output / input  1 each  PC redirect handshake.
REQ-014 SHALL have redirect_pc  output  XLEN  target PC, stable while redirect_valid is high.
REQ-015 SHALL have stall  output  1  freezes commit while the FSM is not in IDLE.
REQ-016 SHALL have trap_cnt  output  CNT_W  count of traps taken.

Function
REQ-017 SHALL implement the FSM states IDLE, WAIT_BUS, TRAP, RET and REDIRECT.
REQ-018 SHALL compute irq_pend = clint_mtip & mstatus_mie & mie_mtie combinationally.
REQ-019 From IDLE, on inst_valid, SHALL apply priority ecall > ebreak > mret > irq_pend, and SHALL ignore all events when inst_valid is low.
REQ-020 For ecall/ebreak, SHALL latch epc = inst_addr and cause = 11 or 3, then go to TRAP.
REQ-021 For irq_pend, SHALL latch epc = inst_nxt_pc and cause = 2^(XLEN-1)+7, then go to WAIT_BUS if bus_busy is high, else to TRAP.
REQ-022 WAIT_BUS SHALL hold until bus_busy is low, then go to TRAP; clint_mtip dropping while in WAIT_BUS does not cancel the interrupt.
REQ-023 TRAP SHALL last exactly one cycle, assert csr_trap_we, drive the latched cause and epc, latch redirect_pc = mtvec, and go to REDIRECT.
REQ-024 mret from IDLE SHALL go to RET; RET SHALL last one cycle, assert csr_ret_we, latch redirect_pc = mepc, and go to REDIRECT.
REQ-025 REDIRECT SHALL hold redirect_valid high until redirect_valid & redirect_ready, then return to IDLE on the next cycle; redirect_pc SHALL NOT change while redirect_valid is high.
REQ-026 stall SHALL be high in every state except IDLE.
REQ-027 Latency SHALL be: commit of ecall -> csr_trap_we 1 cycle later -> redirect_valid 2 cycles later.
REQ-028 A synchronous event and irq_pend in the same cycle SHALL be resolved in favour of the synchronous event; the level-sensitive interrupt is taken at the next commit in IDLE.
REQ-029 trap_cnt SHALL increment by 1 in each TRAP cycle and SHALL wrap from all-ones to 0; it SHALL NOT count RET cycles.
REQ-030 csr_trap_we and csr_ret_we SHALL never be high in the same cycle.

Reset
REQ-031 On rst low, SHALL force, asynchronously, state = IDLE, trap_cnt = 0, and csr_trap_we, csr_ret_we, redirect_valid, stall, trap_cause, trap_epc and redirect_pc all = 0.
REQ-032 Reset asserted mid-sequence (WAIT_BUS, TRAP, RET, REDIRECT) SHALL abandon that sequence with no further strobe.
REQ-033 After rst is released, the first event SHALL be accepted on the first rising edge at which inst_valid is high.

Configuration
REQ-034 Macro TRAP_CTRL_TIMER_IRQ_EN defined: interrupt path present per REQ-018..REQ-022.
REQ-035 Macro TRAP_CTRL_TIMER_IRQ_EN undefined: irq_pend is tied to 0, the WAIT_BUS state is unreachable, and clint_mtip, mstatus_mie, mie_mtie and bus_busy are ignored.

Verification
REQ-036 ecall at inst_addr=0x8000_0100, mtvec=0x8000_0800 -> next cycle csr_trap_we=1 with cause=11 and epc=0x8000_0100; following cycle redirect_valid=1 with redirect_pc=0x8000_0800; trap_cnt=1.
REQ-037 mret with mepc=0x8000_0104, redirect_ready held low 3 cycles -> csr_ret_we pulses once, redirect_valid is held 4 cycles with pc=0x8000_0104 stable, and trap_cnt is unchanged.
REQ-038 mtip=mie=mtie=1, inst_nxt_pc=0x8000_0200, bus_busy high 5 cycles -> FSM in WAIT_BUS 5 cycles, then cause=0x8000_0000_0000_0007 and epc=0x8000_0200.
REQ-039 ecall and irq_pend in the same commit -> cause=11 is taken first; the next commit after return to IDLE takes cause 0x8000_0000_0000_0007.
REQ-040 trap_cnt preloaded to all-ones via 2^CNT_W-1 traps, then one more ecall -> trap_cnt=0.
REQ-041 rst driven low mid-REDIRECT, asynchronously to clk -> redirect_valid and stall go to 0 immediately; build without TRAP_CTRL_TIMER_IRQ_EN and mtip=1 -> no trap is ever taken.
